// File: rtl/mem_stage_pkg.sv
// Shared header for the memory stage: icode/acode/exception constants, access helpers, FSM state.
// Defining MEM_ADDR_CHECK_EN turns misaligned half/word accesses into AdEL/AdES exceptions.
package mem_stage_pkg;

    localparam logic [5:0] IC_LB  = 6'h20;
    localparam logic [5:0] IC_LH  = 6'h21;
    localparam logic [5:0] IC_LW  = 6'h23;
    localparam logic [5:0] IC_LBU = 6'h24;
    localparam logic [5:0] IC_LHU = 6'h25;
    localparam logic [5:0] IC_SB  = 6'h28;
    localparam logic [5:0] IC_SH  = 6'h29;
    localparam logic [5:0] IC_SW  = 6'h2b;

    localparam logic [5:0] AC_NONE = 6'h00;

    localparam logic [5:0] EXC_NONE = 6'b000000;
    localparam logic [5:0] EXC_ADEL = 6'b100100;
    localparam logic [5:0] EXC_ADES = 6'b100101;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit ADDR_CHECK_EN = 1'b1;
`else
    localparam bit ADDR_CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} mem_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] valt;
        logic [5:0]  icode;
        logic [5:0]  acode;
        logic [5:0]  exc_code;
        logic [4:0]  dst;
        logic        in_delay_slot;
    } stage_t;

    function automatic logic is_mem_op(input logic [5:0] icode);
        return icode inside {IC_LB, IC_LH, IC_LW, IC_LBU, IC_LHU, IC_SB, IC_SH, IC_SW};
    endfunction

    function automatic logic is_load(input logic [5:0] icode);
        return icode inside {IC_LB, IC_LH, IC_LW, IC_LBU, IC_LHU};
    endfunction

    function automatic logic load_signed(input logic [5:0] icode);
        return icode inside {IC_LB, IC_LH};
    endfunction

    function automatic logic [1:0] acc_size(input logic [5:0] icode);
        case (icode)
            IC_LB, IC_LBU, IC_SB: return SIZE_BYTE;
            IC_LH, IC_LHU, IC_SH: return SIZE_HALF;
            default:              return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [5:0] icode, input logic [1:0] addr_lo);
        case (acc_size(icode))
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension of a raw 32-bit bus word.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_val
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_byte = i_data[7:0];
        case (i_offset)
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            2'd3:    w_byte = i_data[31:24];
            default: w_byte = i_data[7:0];
        endcase
        w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];

        case (i_size)
            SIZE_BYTE: o_val = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_val = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_val = i_data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: stage register, data-bus request FSM, load/store formatting.
// Optional MEM_ADDR_CHECK_EN (see mem_stage_pkg) raises AdEL/AdES on misaligned accesses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_pc,
    input  logic [31:0] M_addr,
    input  logic [31:0] M_valt,
    input  logic [5:0]  M_icode,
    input  logic [5:0]  M_acode,
    input  logic [5:0]  M_excCode,
    input  logic [4:0]  M_dst,
    input  logic        M_inDelaySlot,
    input  logic        M_stall,
    input  logic        M_bubble,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic [31:0] m_pc,
    output logic [31:0] m_val,
    output logic [31:0] m_badvaddr,
    output logic [5:0]  m_icode,
    output logic [5:0]  m_excCode,
    output logic [4:0]  m_dst,
    output logic        m_inDelaySlot,
    output logic        m_busy
);

    stage_t      r_stage;
    mem_state_t  r_state, w_state_next;
    logic [31:0] r_rdata;

    logic        w_busy, w_latch, w_done, w_in_go;
    logic        w_is_mem, w_misalign, w_mem_go, w_is_load;
    logic [1:0]  w_size;
    logic [31:0] w_bus_addr, w_rdata, w_load_val;
    logic        w_unused;

    assign w_busy  = (r_state == S_REQ  && !(dresp_addr_ok && dresp_data_ok)) ||
                     (r_state == S_WAIT && !dresp_data_ok);
    assign w_done  = (r_state == S_REQ  && dresp_addr_ok && dresp_data_ok) ||
                     (r_state == S_WAIT && dresp_data_ok);
    assign w_latch = !w_busy && !M_stall;
    assign w_in_go = !M_bubble && is_mem_op(M_icode) && !M_excCode[5] &&
                     !(ADDR_CHECK_EN && is_misaligned(M_icode, M_addr[1:0]));

    assign w_is_mem   = is_mem_op(r_stage.icode) && !r_stage.exc_code[5];
    assign w_misalign = ADDR_CHECK_EN && is_misaligned(r_stage.icode, r_stage.addr[1:0]);
    assign w_mem_go   = w_is_mem && !w_misalign;
    assign w_is_load  = is_load(r_stage.icode);
    assign w_size     = acc_size(r_stage.icode);
    assign w_unused   = ^r_stage.acode;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= '0;
            r_state <= S_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_done)
                r_rdata <= dresp_data;
            if (w_latch)
                r_stage <= M_bubble ? '0 : '{pc: M_pc, addr: M_addr, valt: M_valt,
                                             icode: M_icode, acode: M_acode,
                                             exc_code: M_excCode, dst: M_dst,
                                             in_delay_slot: M_inDelaySlot};
        end
    end

    // A retiring access frees the stage the same cycle, so a new op may go straight back to REQ.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_REQ:   if (dresp_addr_ok) w_state_next = dresp_data_ok ? S_IDLE : S_WAIT;
            S_WAIT:  if (dresp_data_ok) w_state_next = S_IDLE;
            default: w_state_next = r_state;
        endcase
        if (w_latch)
            w_state_next = w_in_go ? S_REQ : S_IDLE;
    end

    always_comb begin
        w_bus_addr = r_stage.addr;
        if (!ADDR_CHECK_EN) begin
            if (w_size == SIZE_HALF)
                w_bus_addr[0] = 1'b0;
            else if (w_size == SIZE_WORD)
                w_bus_addr[1:0] = 2'b00;
        end

        dreq_strobe = 4'b0000;
        if (w_is_mem && !w_is_load) begin
            case (w_size)
                SIZE_BYTE: dreq_strobe = 4'b0001 << w_bus_addr[1:0];
                SIZE_HALF: dreq_strobe = 4'b0011 << w_bus_addr[1:0];
                default:   dreq_strobe = 4'b1111;
            endcase
        end

        case (w_size)
            SIZE_BYTE: dreq_data = {4{r_stage.valt[7:0]}};
            SIZE_HALF: dreq_data = {2{r_stage.valt[15:0]}};
            default:   dreq_data = r_stage.valt;
        endcase
    end

    assign dreq_valid = (r_state == S_REQ);
    assign dreq_addr  = w_bus_addr;
    assign dreq_size  = w_size;

    // Forward the bus word in the data_ok cycle so the load result is visible as the stage retires.
    assign w_rdata = w_done ? dresp_data : r_rdata;

    load_align u_load_align (
        .i_data   (w_rdata),
        .i_offset (w_bus_addr[1:0]),
        .i_size   (w_size),
        .i_signed (load_signed(r_stage.icode)),
        .o_val    (w_load_val)
    );

    always_comb begin
        if (!w_mem_go)
            m_val = r_stage.addr;
        else if (w_is_load)
            m_val = w_load_val;
        else
            m_val = '0;

        m_excCode  = r_stage.exc_code;
        m_badvaddr = '0;
        if (w_is_mem && w_misalign) begin
            m_excCode  = w_is_load ? EXC_ADEL : EXC_ADES;
            m_badvaddr = r_stage.addr;
        end
    end

    assign m_pc          = r_stage.pc;
    assign m_icode       = r_stage.icode;
    assign m_dst         = r_stage.dst;
    assign m_inDelaySlot = r_stage.in_delay_slot;
    assign m_busy        = w_busy;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts outputs every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_stage;
    import mem_stage_pkg::*;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] valt;
        logic [5:0]  icode;
        logic [5:0]  acode;
        logic [5:0]  exc;
        logic [4:0]  dst;
        logic        ds;
    } inst_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_pc, M_addr, M_valt;
    logic [5:0]  M_icode, M_acode, M_excCode;
    logic [4:0]  M_dst;
    logic        M_inDelaySlot, M_stall, M_bubble;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        dreq_valid;
    logic [31:0] dreq_addr, dreq_data;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] m_pc, m_val, m_badvaddr;
    logic [5:0]  m_icode, m_excCode;
    logic [4:0]  m_dst;
    logic        m_inDelaySlot, m_busy;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .M_pc(M_pc), .M_addr(M_addr), .M_valt(M_valt),
        .M_icode(M_icode), .M_acode(M_acode), .M_excCode(M_excCode),
        .M_dst(M_dst), .M_inDelaySlot(M_inDelaySlot), .M_stall(M_stall), .M_bubble(M_bubble),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .m_pc(m_pc), .m_val(m_val), .m_badvaddr(m_badvaddr), .m_icode(m_icode),
        .m_excCode(m_excCode), .m_dst(m_dst), .m_inDelaySlot(m_inDelaySlot), .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    // Model: the instruction held in the stage, cycles since it was latched, and its bus timing.
    inst_t       mdl;
    int          k, m_da, m_dd;
    logic [31:0] m_rdata;
    // Stimulus for the next cycle and the timing attached to the instruction currently offered.
    inst_t       nxt;
    int          nxt_da, nxt_dd, pend_da, pend_dd;
    logic [31:0] nxt_rdata, pend_rdata;
    logic        nxt_stall, nxt_bubble, nxt_reset, nxt_stray, nxt_force_ack;
    bit          cur_busy, cur_valid, checking;
    int          n_checks, n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_memic(input logic [5:0] ic);
        return ic == IC_LB || ic == IC_LBU || ic == IC_LH || ic == IC_LHU || ic == IC_LW ||
               ic == IC_SB || ic == IC_SH || ic == IC_SW;
    endfunction

    function automatic bit is_ld(input logic [5:0] ic);
        return ic == IC_LB || ic == IC_LBU || ic == IC_LH || ic == IC_LHU || ic == IC_LW;
    endfunction

    function automatic int nbytes(input logic [5:0] ic);
        if (ic == IC_LB || ic == IC_LBU || ic == IC_SB) return 1;
        if (ic == IC_LH || ic == IC_LHU || ic == IC_SH) return 2;
        return 4;
    endfunction

    function automatic bit mdl_misaligned();
        return (mdl.addr % nbytes(mdl.icode)) != 0;
    endfunction

    function automatic bit mdl_go();
        return is_memic(mdl.icode) && !mdl.exc[5] && !(CHK && mdl_misaligned());
    endfunction

    function automatic logic [31:0] exp_baddr();
        if (CHK) return mdl.addr;
        return mdl.addr - (mdl.addr % nbytes(mdl.icode));
    endfunction

    function automatic logic [31:0] exp_strobe();
        logic [31:0] s;
        if (is_ld(mdl.icode)) return 0;
        s = ((32'd1 << nbytes(mdl.icode)) - 1) << (exp_baddr() % 4);
        return {28'd0, s[3:0]};
    endfunction

    function automatic logic [31:0] exp_data();
        if (nbytes(mdl.icode) == 1) return {24'd0, mdl.valt[7:0]} * 32'h0101_0101;
        if (nbytes(mdl.icode) == 2) return {16'd0, mdl.valt[15:0]} * 32'h0001_0001;
        return mdl.valt;
    endfunction

    function automatic logic [31:0] exp_val();
        logic [31:0] v;
        if (!mdl_go()) return mdl.addr;
        if (!is_ld(mdl.icode)) return 0;
        v = m_rdata >> (8 * (exp_baddr() % 4));
        if (nbytes(mdl.icode) == 1) begin
            v = v & 32'hFF;
            if (mdl.icode == IC_LB && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (nbytes(mdl.icode) == 2) begin
            v = v & 32'hFFFF;
            if (mdl.icode == IC_LH && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_exc();
        if (!mdl.exc[5] && CHK && is_memic(mdl.icode) && mdl_misaligned())
            return is_ld(mdl.icode) ? 32'b100100 : 32'b100101;
        return {26'd0, mdl.exc};
    endfunction

    function automatic logic [31:0] exp_badv();
        if (!mdl.exc[5] && CHK && is_memic(mdl.icode) && mdl_misaligned()) return mdl.addr;
        return 0;
    endfunction

    // One clock: update the model from the inputs seen at this edge, then drive the next cycle.
    task automatic tick();
        bit go, active;
        @(posedge clk);
        if (reset) begin
            mdl = '0;
            k = 1000;
        end else if (!cur_busy && !M_stall) begin
            mdl = M_bubble ? '0 : inst_t'{M_pc, M_addr, M_valt, M_icode, M_acode,
                                           M_excCode, M_dst, M_inDelaySlot};
            k = 0;
            m_da = pend_da;
            m_dd = pend_dd;
            m_rdata = pend_rdata;
        end else if (k < 1000) begin
            k++;
        end
        #1;
        reset = nxt_reset;
        {M_pc, M_addr, M_valt, M_icode, M_acode, M_excCode, M_dst, M_inDelaySlot} = nxt;
        M_stall = nxt_stall;
        M_bubble = nxt_bubble;
        pend_da = nxt_da;
        pend_dd = nxt_dd;
        pend_rdata = nxt_rdata;
        go = mdl_go();
        active = go && k <= m_da + m_dd;
        dresp_addr_ok = (go && k == m_da) ||
                        (!active && (nxt_force_ack || (nxt_stray && $urandom_range(0, 3) == 0)));
        dresp_data_ok = (go && k == m_da + m_dd) ||
                        (!active && (nxt_force_ack || (nxt_stray && $urandom_range(0, 3) == 0)));
        dresp_data = (go && k == m_da + m_dd) ? m_rdata : $urandom;
        cur_busy = go && k < m_da + m_dd;
        cur_valid = go && k <= m_da;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("m_pc", m_pc, mdl.pc);
            check("m_icode", {26'd0, m_icode}, {26'd0, mdl.icode});
            check("m_dst", {27'd0, m_dst}, {27'd0, mdl.dst});
            check("m_inDelaySlot", {31'd0, m_inDelaySlot}, {31'd0, mdl.ds});
            check("m_excCode", {26'd0, m_excCode}, exp_exc());
            check("m_badvaddr", m_badvaddr, exp_badv());
            check("m_busy", {31'd0, m_busy}, {31'd0, cur_busy});
            check("dreq_valid", {31'd0, dreq_valid}, {31'd0, cur_valid});
            if (!cur_busy)
                check("m_val", m_val, exp_val());
            if (cur_valid) begin
                check("dreq_addr", dreq_addr, exp_baddr());
                check("dreq_size", {30'd0, dreq_size},
                      nbytes(mdl.icode) == 1 ? 32'd0 : nbytes(mdl.icode) == 2 ? 32'd1 : 32'd2);
                check("dreq_strobe", {28'd0, dreq_strobe}, exp_strobe());
                check("dreq_data", dreq_data, exp_data());
            end
        end
    end

    task automatic set_nop();
        nxt = '0;
        nxt.icode = 6'h01;
        nxt.pc = 32'hDEAD_0000;
        nxt.addr = 32'h0000_5A5A;
        {nxt_stall, nxt_bubble, nxt_reset, nxt_stray, nxt_force_ack} = '0;
        nxt_da = 0;
        nxt_dd = 0;
        nxt_rdata = 0;
    endtask

    // Offer one instruction, then let it be latched; returns in its first stage cycle.
    task automatic present(input logic [5:0] ic, input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] valt, input logic [5:0] exc,
                           input int da, input int dd, input logic [31:0] rdata);
        set_nop();
        nxt.icode = ic;
        nxt.pc = pc;
        nxt.addr = addr;
        nxt.valt = valt;
        nxt.exc = exc;
        nxt.dst = 5'd7;
        nxt_da = da;
        nxt_dd = dd;
        nxt_rdata = rdata;
        tick();
        set_nop();
        tick();
    endtask

    // Runs an op to completion; reports busy cycles, bus request seen and outputs in its last cycle.
    task automatic run_op(input logic [5:0] ic, input logic [31:0] addr, input logic [31:0] valt,
                          input logic [5:0] exc, input int da, input int dd,
                          input logic [31:0] rdata, output int busy_n, output bit seen,
                          output logic [31:0] baddr, output logic [3:0] strobe,
                          output logic [31:0] bdata, output logic [1:0] size,
                          output logic [31:0] val, output logic [5:0] exc_o,
                          output logic [31:0] badv);
        present(ic, 32'h0000_0100, addr, valt, exc, da, dd, rdata);
        busy_n = 0;
        seen = 0;
        {baddr, strobe, bdata, size} = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dreq_valid && !seen) begin
                seen = 1;
                {baddr, strobe, bdata, size} = {dreq_addr, dreq_strobe, dreq_data, dreq_size};
            end
            if (!m_busy) break;
            busy_n++;
            tick();
        end
        val = m_val;
        exc_o = m_excCode;
        badv = m_badvaddr;
    endtask

    int          bn;
    bit          sn;
    logic [31:0] ba, bd, v, bv;
    logic [3:0]  st;
    logic [1:0]  sz;
    logic [5:0]  ex;

    initial begin
        {M_pc, M_addr, M_valt, M_icode, M_acode, M_excCode, M_dst, M_inDelaySlot} = '0;
        {M_stall, M_bubble, dresp_addr_ok, dresp_data_ok} = '0;
        dresp_data = '0;
        reset = 1'b1;
        mdl = '0;
        k = 1000;
        {m_da, m_dd, pend_da, pend_dd} = '0;
        {m_rdata, pend_rdata} = '0;
        {cur_busy, cur_valid, checking} = '0;
        n_checks = 0;
        n_pass = 0;
        set_nop();
        nxt_reset = 1'b1;
        tick();
        set_nop();
        tick();
        checking = 1'b1;

        // LW, addr_ok+data_ok together one cycle after the request opens.
        run_op(IC_LW, 32'h8000_0010, 32'h0, 6'd0, 1, 0, 32'h1234_5678,
               bn, sn, ba, st, bd, sz, v, ex, bv);
        check("lw_busy_cycles", bn, 1);
        check("lw_val", v, 32'h1234_5678);
        check("lw_size", {30'd0, sz}, 2);
        check("lw_strobe", {28'd0, st}, 0);
        check("lw_addr", ba, 32'h8000_0010);

        // LB / LBU at offset 3, data_ok three cycles after addr_ok.
        run_op(IC_LB, 32'h8000_0103, 32'h0, 6'd0, 1, 3, 32'h80FF_FFFF,
               bn, sn, ba, st, bd, sz, v, ex, bv);
        check("lb_busy_cycles", bn, 4);
        check("lb_val", v, 32'hFFFF_FF80);
        run_op(IC_LBU, 32'h8000_0103, 32'h0, 6'd0, 1, 3, 32'h80FF_FFFF,
               bn, sn, ba, st, bd, sz, v, ex, bv);
        check("lbu_busy_cycles", bn, 4);
        check("lbu_val", v, 32'h0000_0080);

        // SH at offset 2.
        run_op(IC_SH, 32'h8000_0202, 32'h0000_ABCD, 6'd0, 1, 0, 32'h0,
               bn, sn, ba, st, bd, sz, v, ex, bv);
        check("sh_strobe", {28'd0, st}, 32'b1100);
        check("sh_data", bd, 32'hABCD_ABCD);
        check("sh_val", v, 0);

        // Misaligned LW.
        run_op(IC_LW, 32'h8000_0301, 32'h0, 6'd0, 1, 0, 32'h0BAD_F00D,
               bn, sn, ba, st, bd, sz, v, ex, bv);
        if (CHK) begin
            check("misalign_req_seen", {31'd0, sn}, 0);
            check("misalign_exc", {26'd0, ex}, 32'b100100);
            check("misalign_badv", bv, 32'h8000_0301);
        end else begin
            check("misalign_addr", ba, 32'h8000_0300);
            check("misalign_exc", {26'd0, ex}, 0);
            check("misalign_badv", bv, 0);
        end

        // SW carrying an incoming exception.
        run_op(IC_SW, 32'h8000_0500, 32'h1111_2222, 6'b101100, 1, 0, 32'h0,
               bn, sn, ba, st, bd, sz, v, ex, bv);
        check("exc_req_seen", {31'd0, sn}, 0);
        check("exc_busy_cycles", bn, 0);
        check("exc_pass", {26'd0, ex}, 32'b101100);

        // Reset while waiting for data, followed by a stale data_ok.
        present(IC_LW, 32'h0000_0400, 32'h8000_0400, 32'h0, 6'd0, 0, 6, 32'hCAFE_BABE);
        tick();
        tick();
        nxt_reset = 1'b1;
        tick();
        set_nop();
        nxt_force_ack = 1'b1;
        tick();
        @(negedge clk);
        check("rst_valid", {31'd0, dreq_valid}, 0);
        check("rst_busy", {31'd0, m_busy}, 0);
        check("rst_val", m_val, 0);
        check("rst_pc", m_pc, 0);
        set_nop();
        tick();
        @(negedge clk);
        check("stale_busy", {31'd0, m_busy}, 0);
        check("stale_valid", {31'd0, dreq_valid}, 0);

        // Stall and bubble offered while busy must not disturb the stage.
        present(IC_LW, 32'h0000_1000, 32'h8000_0600, 32'h0, 6'd0, 2, 2, 32'h0F0F_0F0F);
        for (int i = 0; i < 3; i++) begin
            nxt.pc = 32'h0000_2000 + i;
            nxt_stall = (i % 2 == 0);
            nxt_bubble = (i % 2 == 1);
            tick();
            @(negedge clk);
            check("hold_pc", m_pc, 32'h0000_1000);
        end
        set_nop();
        for (int i = 0; i < 4; i++) tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            nxt.pc = $urandom;
            nxt.addr = $urandom;
            nxt.valt = $urandom;
            nxt.acode = 6'($urandom);
            nxt.dst = 5'($urandom);
            nxt.ds = 1'($urandom);
            case ($urandom_range(0, 9))
                0: nxt.icode = IC_LB;
                1: nxt.icode = IC_LBU;
                2: nxt.icode = IC_LH;
                3: nxt.icode = IC_LHU;
                4: nxt.icode = IC_LW;
                5: nxt.icode = IC_SB;
                6: nxt.icode = IC_SH;
                7: nxt.icode = IC_SW;
                default: nxt.icode = 6'($urandom_range(0, 31));
            endcase
            nxt.exc = ($urandom_range(0, 9) == 0) ? {1'b1, 5'($urandom)} : 6'd0;
            nxt_da = $urandom_range(0, 3);
            nxt_dd = $urandom_range(0, 3);
            nxt_rdata = $urandom;
            nxt_stall = ($urandom_range(0, 4) == 0);
            nxt_bubble = ($urandom_range(0, 9) == 0);
            nxt_reset = ($urandom_range(0, 49) == 0);
            nxt_stray = 1'b1;
            nxt_force_ack = 1'b0;
            tick();
        end
        set_nop();
        for (int i = 0; i < 12; i++) tick();
        @(negedge clk);
        checking = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have inputs M_pc, M_addr, M_valt  in  32 each  PC, effective address / ALU result, store data from execute stage.
REQ-004 SHALL have inputs M_icode, M_acode, M_excCode  in  6 each; M_dst  in  5; M_inDelaySlot, M_stall, M_bubble  in  1.
REQ-005 SHALL have data-bus outputs dreq_valid 1, dreq_addr 32, dreq_size 2 (0=byte, 1=half, 2=word), dreq_strobe 4 (0 = read), dreq_data 32.
REQ-006 SHALL have data-bus inputs dresp_addr_ok 1, dresp_data_ok 1, dresp_data 32.
REQ-007 SHALL have outputs m_pc 32, m_val 32 (writeback value), m_badvaddr 32, m_icode 6, m_excCode 6, m_dst 5, m_inDelaySlot 1, m_busy 1 (stall request to pipeline control).

Function
REQ-008 SHALL latch all M_* inputs into the stage register on posedge when not busy and M_stall=0; M_bubble=1 latches zeros; M_stall=1 holds.
REQ-009 SHALL hold the stage register unconditionally while m_busy=1, ignoring M_stall and M_bubble.
REQ-010 SHALL treat LB, LBU, LH, LHU, LW, SB, SH, SW with latched m_excCode[5]=0 as memory ops; all other icodes pass through with m_val = latched M_addr.
REQ-011 SHALL implement FSM IDLE -> REQ on latching a legal memory op; REQ -> WAIT on dresp_addr_ok without dresp_data_ok; REQ -> IDLE on dresp_addr_ok with dresp_data_ok same cycle; WAIT -> IDLE on dresp_data_ok.
REQ-012 SHALL drive dreq_valid=1 only in REQ; dreq_addr, dreq_size, dreq_strobe, dreq_data SHALL stay stable from REQ entry until addr_ok.
REQ-013 SHALL drive m_busy=1 in REQ and WAIT, and 0 in the cycle data_ok is sampled, so minimum memory-op latency is 1 cycle after latch (same-cycle addr_ok+data_ok).
REQ-014 SHALL, for stores, set strobe SB = 0001<<addr[1:0], SH = 0011<<addr[1:0], SW = 1111; data replicated across byte/half lanes.
REQ-015 SHALL, for loads, capture dresp_data on data_ok, select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; result held on m_val until next latch.
REQ-016 SHALL drive m_val=0 for stores.
REQ-017 SHALL pass m_excCode from latched M_excCode when its bit5 is set; that instruction issues no bus request.
REQ-018 SHALL ignore dresp_addr_ok/dresp_data_ok in IDLE.

Reset
REQ-019 SHALL on reset clear the stage register, m_val, m_badvaddr, m_excCode to 0, FSM to IDLE, dreq_valid=0 and m_busy=0 the next cycle, including mid-transaction; a later stale data_ok SHALL be ignored per REQ-018.

Configuration
REQ-020 SHALL with MEM_ADDR_CHECK_EN defined flag misaligned half/word accesses: loads m_excCode=6'b100100 (AdEL), stores 6'b100101 (AdES), m_badvaddr=address, no bus request.
REQ-021 SHALL without MEM_ADDR_CHECK_EN force misaligned address low bits to alignment (half: bit0=0, word: bits1:0=0), raise no exception, m_badvaddr=0.

Structure
REQ-022 SHALL take icode/acode and exception-code constants from the shared header package; mem FSM state typedef (IDLE/REQ/WAIT) SHALL be added there.
REQ-023 SHALL place load lane-select/extension in sub-module load_align; the remainder is one module.

Verification
REQ-024 LW addr 0x8000_0010, addr_ok+data_ok same cycle with data 0x1234_5678 -> one busy cycle, m_val=0x1234_5678, dreq_size=2, strobe=0.
REQ-025 LB addr 0x...03, data_ok 3 cycles after addr_ok, data 0x80FF_FFFF -> m_busy 4 cycles, m_val=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-026 SH addr 0x...02, data 0x0000_ABCD -> strobe 1100, dreq_data 0xABCD_ABCD, m_val=0.
REQ-027 MEM_ADDR_CHECK_EN, LW addr 0x...01 -> dreq_valid never 1, m_excCode=6'b100100, m_badvaddr=0x...01; without macro -> dreq_addr 0x...00, no exception.
REQ-028 reset asserted in WAIT, then data_ok -> dreq_valid=0, m_busy=0, m_val=0, FSM IDLE; M_stall asserted while busy -> register unchanged.
REQ-029 incoming M_excCode=6'b101100 on SW -> no request, m_excCode=6'b101100 passed through.
